// File: rtl/mmio_io_responder.sv
// Device-side MMIO responder: byte TX FIFO drained over valid/ready, and a single-entry
// RX latch that raises irr until the CPU acknowledges.
module mmio_io_responder #(
  parameter logic [31:0] TX_ADDR   = 32'h0000_1000,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_1004,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        w_req,
  input  logic [31:0] w_data,
  output logic        w_busy,
  output logic        irr,
  output logic [31:0] r_data,
  input  logic        ack,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        err_tx_ovf,
  output logic        err_rx_ovr
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StPend} rx_state_e;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_tx_ovf_q, err_tx_ovf_d;
  logic            err_rx_ovr_q, err_rx_ovr_d;
  logic [31:0]     r_data_q, r_data_d;
  rx_state_e       state_q, state_d;

  logic push, push_ok, pop, ctrl_wr, flush, clr_err, full, rx_load, rx_drop;

  logic unused_wdata;
  assign unused_wdata = ^w_data[31:8];

  assign full    = (count_q == CntFull);
  assign push    = w_req && (addr == TX_ADDR);
  assign ctrl_wr = w_req && (addr == CTRL_ADDR);
  assign flush   = ctrl_wr && w_data[0];
  assign clr_err = ctrl_wr && w_data[1];
  assign push_ok = push && !full;
  // A flush in the same cycle swallows any pop the sink attempted.
  assign pop     = (count_q != '0) && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop)     head_d = head_q + 1'b1;
      count_d = count_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) mem_q[tail_q] <= w_data[7:0];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // RX interrupt FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // RX interrupt FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid)        state_d = StPend;
      StPend: if (ack && !in_valid) state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  // RX interrupt FSM: outputs and datapath controls.
  always_comb begin
    irr     = 1'b0;
    rx_load = 1'b0;
    rx_drop = 1'b0;
    unique case (state_q)
      StIdle: rx_load = in_valid;
      StPend: begin
        irr     = 1'b1;
        rx_load = in_valid && ack;
        rx_drop = in_valid && !ack;
      end
      default: ;
    endcase
  end

  always_comb begin
    r_data_d     = rx_load ? {24'h0, in_data} : r_data_q;
    err_tx_ovf_d = clr_err ? 1'b0 : (err_tx_ovf_q || (push && full));
    err_rx_ovr_d = clr_err ? 1'b0 : (err_rx_ovr_q || rx_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q     <= '0;
      err_tx_ovf_q <= 1'b0;
      err_rx_ovr_q <= 1'b0;
    end else begin
      r_data_q     <= r_data_d;
      err_tx_ovf_q <= err_tx_ovf_d;
      err_rx_ovr_q <= err_rx_ovr_d;
    end
  end

  assign w_busy     = full;
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[head_q] : 8'h00;
  assign r_data     = r_data_q;
  assign err_tx_ovf = err_tx_ovf_q;
  assign err_rx_ovr = err_rx_ovr_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: TX FIFO order/overflow/flush, RX latch/ack, async reset.
module tb_mmio_io_responder;

  localparam logic [31:0] TxAddr   = 32'h0000_1000;
  localparam logic [31:0] CtrlAddr = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        w_req = 1'b0;
  logic [31:0] w_data = '0;
  logic        w_busy, irr, out_valid, err_tx_ovf, err_rx_ovr;
  logic [31:0] r_data;
  logic [7:0]  out_data;
  logic        ack = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  int checks = 0;
  int errors = 0;

  mmio_io_responder #(
    .TX_ADDR  (TxAddr),
    .CTRL_ADDR(CtrlAddr),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .w_req     (w_req),
    .w_data    (w_data),
    .w_busy    (w_busy),
    .irr       (irr),
    .r_data    (r_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .err_tx_ovf(err_tx_ovf),
    .err_rx_ovr(err_rx_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; w_data = d; w_req = 1'b1;
    step();
    w_req = 1'b0;
  endtask

  task automatic rx(input logic [7:0] d, input logic with_ack);
    in_data = d; in_valid = 1'b1; ack = with_ack;
    step();
    in_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_data"}, {24'h0, out_data}, {24'h0, exp});
    step();
  endtask

  initial begin
    // 1: reset and simple in-order drain
    #3;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy", {31'h0, w_busy}, 32'h0);
    check("rst_irr", {31'h0, irr}, 32'h0);
    check("rst_rdata", r_data, 32'h0);
    #10 rst_n = 1'b1;
    step();
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_errs", {30'h0, err_tx_ovf, err_rx_ovr}, 32'h0);
    wr(TxAddr, 32'h41);
    check("t1_lat1_valid", {31'h0, out_valid}, 32'h1);
    wr(TxAddr, 32'h42);
    wr(TxAddr, 32'h143);
    check("t1_busy", {31'h0, w_busy}, 32'h0);
    check("t1_head", {24'h0, out_data}, 32'h41);
    step();
    check("t1_hold", {24'h0, out_data}, 32'h41);
    out_ready = 1'b1;
    drain_expect("t1_b0", 8'h41);
    drain_expect("t1_b1", 8'h42);
    drain_expect("t1_b2", 8'h43);
    check("t1_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // 2: fill, overflow, drain, refill across pointer wrap
    for (int i = 1; i <= 4; i++) wr(TxAddr, i);
    check("t2_busy", {31'h0, w_busy}, 32'h1);
    wr(TxAddr, 32'h99);
    check("t2_ovf", {31'h0, err_tx_ovf}, 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) drain_expect("t2_d", 8'(i));
    check("t2_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(TxAddr, 32'hA0 + i);
    check("t2_busy2", {31'h0, w_busy}, 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drain_expect("t2_w", 8'(8'hA0 + i));
    check("t2_empty2", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    wr(CtrlAddr, 32'h2);
    check("t2_clr", {31'h0, err_tx_ovf}, 32'h0);

    // 3: simultaneous push/pop, mid-level and full
    wr(TxAddr, 32'hB0);
    wr(TxAddr, 32'hB1);
    out_ready = 1'b1;
    wr(TxAddr, 32'hB2);
    out_ready = 1'b0;
    check("t3_mid_head", {24'h0, out_data}, 32'hB1);
    wr(TxAddr, 32'hB3);
    check("t3_not_full", {31'h0, w_busy}, 32'h0);
    wr(TxAddr, 32'hB4);
    check("t3_full", {31'h0, w_busy}, 32'h1);
    out_ready = 1'b1;
    wr(TxAddr, 32'hC5);
    out_ready = 1'b0;
    check("t3_full_pp_busy", {31'h0, w_busy}, 32'h0);
    check("t3_full_pp_ovf", {31'h0, err_tx_ovf}, 32'h1);
    out_ready = 1'b1;
    drain_expect("t3_d2", 8'hB2);
    drain_expect("t3_d3", 8'hB3);
    drain_expect("t3_d4", 8'hB4);
    check("t3_empty", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    wr(TxAddr, 32'hD0);
    wr(TxAddr, 32'hD1);
    out_ready = 1'b1;
    wr(CtrlAddr, 32'h3);
    out_ready = 1'b0;
    check("t3_flush", {31'h0, out_valid}, 32'h0);
    check("t3_flush_clr", {31'h0, err_tx_ovf}, 32'h0);
    wr(TxAddr, 32'hE0);
    check("t3_after_flush", {24'h0, out_data}, 32'hE0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 4: RX latch, overrun, ack, clear
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_idle_ack", {31'h0, irr}, 32'h0);
    rx(8'h5A, 1'b0);
    check("t4_irr", {31'h0, irr}, 32'h1);
    check("t4_rdata", r_data, 32'h5A);
    rx(8'h11, 1'b0);
    check("t4_ovr_rdata", r_data, 32'h5A);
    check("t4_ovr", {31'h0, err_rx_ovr}, 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_ack", {31'h0, irr}, 32'h0);
    check("t4_retain", r_data, 32'h5A);
    wr(CtrlAddr, 32'h2);
    check("t4_clr", {30'h0, err_tx_ovf, err_rx_ovr}, 32'h0);
    rx(8'h22, 1'b0);
    addr = CtrlAddr; w_data = 32'h2; w_req = 1'b1;
    rx(8'h33, 1'b0);
    w_req = 1'b0;
    check("t4_clr_wins", {31'h0, err_rx_ovr}, 32'h0);
    ack = 1'b1; step(); ack = 1'b0;

    // 5: ack and new byte in the same cycle
    rx(8'h5A, 1'b0);
    rx(8'h77, 1'b1);
    check("t5_irr", {31'h0, irr}, 32'h1);
    check("t5_rdata", r_data, 32'h77);
    check("t5_no_ovr", {31'h0, err_rx_ovr}, 32'h0);
    ack = 1'b1; step(); ack = 1'b0;
    check("t5_ack", {31'h0, irr}, 32'h0);

    // 6: asynchronous reset mid-cycle with data queued and pending
    wr(TxAddr, 32'hF1);
    wr(TxAddr, 32'hF2);
    wr(TxAddr, 32'hF3);
    rx(8'h66, 1'b0);
    check("t6_pre_irr", {31'h0, irr}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    check("t6_rst_data", {24'h0, out_data}, 32'h0);
    check("t6_rst_irr", {31'h0, irr}, 32'h0);
    check("t6_rst_rdata", r_data, 32'h0);
    #1 rst_n = 1'b1;
    step();
    wr(TxAddr, 32'h01);
    check("t6_fresh", {24'h0, out_data}, 32'h01);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6_no_stale", {31'h0, out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder on the CPU's data-write and interrupt interface; it is the device-side end of the CPU's addr / w_req / w_data / w_busy and irr / r_data / ack signals.
- Accepts byte writes into a TX FIFO and drains them to a byte-stream sink using a valid/ready handshake.
- Latches bytes arriving from a byte-stream source into r_data and raises irr until the CPU acknowledges with ack.

Parameters:
TX_ADDR, 32'h0000_1000, write address that enqueues w_data[7:0] into the TX FIFO
CTRL_ADDR, 32'h0000_1004, control write address: bit0=1 flushes TX FIFO, bit1=1 clears sticky error flags
DEPTH, 4, TX FIFO depth; power of two, at least 2

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  32  write address from CPU
w_req  in  1  single-cycle write request from CPU
w_data  in  32  write data from CPU
w_busy  out  1  TX FIFO full; CPU must not issue w_req to TX_ADDR while high
irr  out  1  interrupt request; high while an RX byte is pending
r_data  out  32  pending RX byte, zero-extended
ack  in  1  single-cycle interrupt acknowledge from CPU
out_valid  out  1  TX FIFO non-empty
out_data  out  8  TX FIFO head byte
out_ready  in  1  sink accepts the head byte when out_valid && out_ready
in_valid  in  1  single-cycle pulse: new RX byte present
in_data  in  8  RX byte
err_tx_ovf  out  1  sticky: a push was dropped because the FIFO was full
err_rx_ovr  out  1  sticky: an RX byte was dropped because one was already pending

Behaviour:
Reset:
- rst_n low asynchronously clears the FIFO (head = tail = count = 0), irr, r_data, err_tx_ovf and err_rx_ovr.
- Consequently out_valid=0, out_data=0 and w_busy=0 during and after reset.
- Reset asserted mid-transfer discards all queued and pending data; nothing is replayed afterwards.

TX FIFO:
- Circular buffer with head and tail pointers of width log2(DEPTH); pointers wrap from DEPTH-1 to 0. A separate count register spans 0..DEPTH.
- push = w_req && addr==TX_ADDR. pop = out_valid && out_ready.
- w_busy = (count==DEPTH); out_valid = (count!=0); out_data = mem[head]. All three are decoded from registers only, with no combinational path from the inputs.
- Push when not full: mem[tail] <= w_data[7:0], tail increments, count increments. Upper w_data bits are ignored.
- Push when full: data is dropped and err_tx_ovf <= 1. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop when 0 < count < DEPTH: both are performed and count is unchanged.
- Push when empty: out_valid rises on the next cycle, so minimum write-to-sink latency is 1 cycle.
- Pop when empty has no effect.
- out_data holds stable while out_valid && !out_ready.

Control write (w_req && addr==CTRL_ADDR):
- bit0 flush: head = tail = count = 0, and any pop in the same cycle is discarded.
- bit1: clears both sticky error flags. Clearing wins over an error event in the same cycle.
- Writes to any other address are ignored.

RX interrupt state machine, states IDLE (irr=0) and PEND (irr=1):
- IDLE + in_valid: r_data <= {24'b0, in_data}, next state PEND.
- PEND + ack + !in_valid: next state IDLE. r_data retains its last value.
- PEND + ack + in_valid: r_data <= new byte, stay in PEND. The ack consumes the old byte.
- PEND + in_valid + !ack: byte is dropped, err_rx_ovr <= 1, r_data unchanged.
- IDLE + ack: ignored.
- irr and r_data are registered, so in_valid to irr latency is 1 cycle.

Handshake and timing:
- The TX and RX paths are independent and may act in the same cycle.
- No output depends combinationally on any input.

Test Plan:
1. Reset, then three writes to TX_ADDR of 0x41, 0x42, 0x143 with out_ready=0 -> count=3, w_busy=0, out_data=0x41. Raise out_ready -> 0x41, 0x42, 0x43 appear on consecutive cycles, then out_valid=0.
2. Four writes with out_ready=0 (DEPTH=4) -> w_busy=1 after the 4th. A 5th write of 0x99 -> dropped, err_tx_ovf=1. Drain -> exactly 4 bytes in order, with correct pointer wrap on a second fill of 4.
3. FIFO at count=2 with push and pop in the same cycle -> count stays 2 and order is preserved. Full FIFO with push and pop in the same cycle -> push dropped, count=3, err_tx_ovf=1.
4. in_valid with 0x5A -> next cycle irr=1, r_data=0x5A. in_valid with 0x11 while pending -> r_data stays 0x5A, err_rx_ovr=1. ack -> irr=0. Write CTRL_ADDR=2 -> both error flags 0.
5. Pending 0x5A, then ack and in_valid(0x77) in the same cycle -> irr remains 1, r_data=0x77, err_rx_ovr stays 0.
6. FIFO holding 3 bytes and irr=1, then rst_n pulsed low mid-cycle -> all outputs 0 immediately (asynchronous). After release, a write of 0x01 gives out_data=0x01, with no stale data.
